// File: rtl/if_prefetch.sv
// Instruction-fetch prefetcher: issues sequential synchronous IMEM reads into a
// small FIFO, handles branch/jalr redirects, and parks on a misaligned target.
module if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14,
  parameter int          QDEPTH   = 4
) (
  input  logic               clk_cpu,
  input  logic               rst_cpu_n,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               jalr_sel,
  input  logic [31:0]        jalr_addr,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_inst,
  output logic [31:0]        out_pc,
  output logic               out_misalign,
  output logic [31:0]        fetch_pc
);

  localparam int              PW     = $clog2(QDEPTH);
  localparam logic [0:0]      S_RUN  = 1'b0;
  localparam logic [0:0]      S_HALT = 1'b1;
  localparam logic [PW+1:0]   QD     = (PW+2)'(QDEPTH);
  localparam logic [31:0]     NOP    = 32'h0000_0013;

  logic [0:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   req_pc_q;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic [31:0]   q_inst [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];
  logic          q_mis  [QDEPTH];

  logic          redir, deq, space, aligned, run, issue;
  logic          mem_enq, mis_enq, enq;
  logic [31:0]   target, enq_pc, enq_inst;
  logic [PW+1:0] occ;

  assign redir   = redirect | jalr_sel;
  assign target  = jalr_sel ? (jalr_addr & ~32'h1) : redirect_pc;
  assign deq     = out_valid & out_ready;
  // Occupancy after this edge: the in-flight response always lands, so it must be reserved.
  assign occ     = {1'b0, count_q} + {{(PW+1){1'b0}}, inflight_q} - {{(PW+1){1'b0}}, deq};
  assign space   = occ < QD;
  assign aligned = (fetch_pc_q[1:0] == 2'b00);
  assign run     = (state_q == S_RUN);
  assign issue   = run & ~redir & aligned & space;
  assign mem_enq = inflight_q & ~redir;
  // A misaligned PC only follows a redirect or reset, so no read is in flight then.
  assign mis_enq = run & ~redir & ~aligned & space & ~inflight_q;
  assign enq     = mem_enq | mis_enq;
  assign enq_pc   = mem_enq ? req_pc_q   : fetch_pc_q;
  assign enq_inst = mem_enq ? imem_rdata : NOP;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redir) begin
      state_d    = S_RUN;
      fetch_pc_d = target;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue)   fetch_pc_d = fetch_pc_q + 32'd4;
      if (mis_enq) state_d    = S_HALT;
      if (enq)     tail_d     = tail_q + PW'(1);
      if (deq)     head_d     = head_q + PW'(1);
      count_d = count_q + {{PW{1'b0}}, enq} - {{PW{1'b0}}, deq};
    end
  end

  always_ff @(posedge clk_cpu or negedge rst_cpu_n) begin
    if (!rst_cpu_n) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Datapath storage carries no reset; validity is tracked by count_q and inflight_q.
  always_ff @(posedge clk_cpu) begin
    if (issue) req_pc_q <= fetch_pc_q;
    if (enq) begin
      q_inst[tail_q] <= enq_inst;
      q_pc[tail_q]   <= enq_pc;
      q_mis[tail_q]  <= ~mem_enq;
    end
  end

  assign imem_en      = issue & rst_cpu_n;
  assign imem_addr    = fetch_pc_q[IMEM_AW+1:2];
  assign fetch_pc     = fetch_pc_q;
  assign out_valid    = (count_q != '0);
  assign out_inst     = out_valid ? q_inst[head_q] : 32'h0;
  assign out_pc       = out_valid ? q_pc[head_q]   : 32'h0;
  assign out_misalign = out_valid & q_mis[head_q];

endmodule
